mtm_alu_packet_rx: RTL and testbench
====================================

# mtm_alu_packet_rx

Parametrised packet receiver for the serial ALU front end and the next generation of the ALU deserializer. It recovers 11-bit serial frames from `sin`, assembles `N_OPS` operands of `DATA_W` bits plus a command byte, and checks byte count, CRC4 and opcode. It delivers one decoded packet per valid/ready handshake to the ALU core. It sits between the `sin` pad and the core.

## Interface
- `DATA_W`, 32: operand width in bits; must be a multiple of 8 and at least 8.
- `N_OPS`, 2: number of operands per packet; must be at least 1.
- `OP_MASK`, 8'b0011_0011: opcode legality bitmap; bit k set means opcode k is legal (defaults are AND=000, OR=001, ADD=100, SUB=101).
- `clk` in 1: clock; all logic is posedge.
- `rst` in 1: reset, **asynchronous, active-high**.
- `sin` in 1: serial input; idles at 1; one bit per clock.
- `out_valid` out 1: a decoded packet is held on the outputs.
- `out_ready` in 1: the consumer accepts the packet.
- `ops` out N_OPS*DATA_W: operands; the first-transmitted operand occupies the top `DATA_W` bits.
- `op` out 3: opcode from the command byte.
- `err` out 3: error flags {data, crc, op}.
- `drop` out 1: one-cycle pulse when a completed packet is discarded because the output register is full.

## Operation
- **Frame format**: start bit 0, type bit (0 = data, 1 = cmd), 8 bits MSB first, stop bit 1.
- **Bit FSM**: IDLE → TYPE → BITS (8 cycles) → STOP → IDLE.
  - IDLE leaves on `sin`=0.
  - STOP with `sin`=0 is a framing error.
- **Data bytes**:
  - Each data byte shifts left into the operand register.
  - The byte counter saturates at `N_OPS*DATA_W/8 + 1`.
  - CRC4 is updated bit-serially over every data bit.
- **CRC4**:
  - Polynomial x^4+x+1, initial value 0.
  - Covers all data bits in transmission order, then the 4 bits {1'b1, op[2:0]}.
- **Cmd byte**: layout is {1'b0, op[2:0], crc[3:0]}. A cmd byte completes the packet. Error evaluation uses strict priority:
  1. `err_data` if the byte count is not equal to `N_OPS*DATA_W/8`. The CRC and opcode checks are skipped.
  2. Otherwise `err_crc` if the received CRC is not equal to the computed CRC.
  3. Otherwise `err_op` if `OP_MASK[op]` is 0.
- **Framing error**:
  - The partial packet is aborted.
  - A packet with `err`=3'b100 and `ops`=0 is delivered immediately.
  - The bit FSM returns to IDLE and needs `sin`=1 before it accepts a new start bit.
- **Packet reset**: after any packet completes, the byte counter, CRC and shift register clear.
- **Output register**: one entry deep.
  - The entry loads only when `out_valid`=0, or when `out_valid`&`out_ready` in the same cycle.
  - If the register is full and not draining, the new packet is discarded and `drop` pulses.
  - Outputs are stable while `out_valid`=1 and `out_ready`=0.
- **Reset values**: `out_valid`=0, `ops`=0, `op`=0, `err`=0, `drop`=0; FSMs at IDLE; counters and CRC at 0.

## Timing
- **Latency**: the stop bit of the cmd byte is sampled in cycle t; `out_valid`=1 from t+1.
- **Handshake**: `out_valid` falls at the edge after `out_valid`&`out_ready`, unless a new packet loads in that same edge.
- **Back-to-back**: a start bit in the cycle right after a stop bit is received.
- **Throughput**: minimum packet period is (N_OPS*DATA_W/8 + 1)*11 cycles.
- **Reset**: asserting `rst` mid-frame clears everything immediately. Reception resumes at the first 0 on `sin` after `rst` deasserts.
- **Boundary cases**:
  - `sin` = 0 in IDLE right after reset is treated as a start bit.
  - A cmd byte with zero preceding data bytes raises `err_data`.
  - More data bytes than expected are counted (saturating) and raise `err_data` at the cmd byte. The operand register keeps the last `N_OPS*DATA_W` bits.

## Structure
- Package `mtm_alu_pkg` holds:
  - frame constants (frame length 11, type values);
  - the `op_t` enum (AND, OR, ADD, SUB);
  - `ERR_DATA`/`ERR_CRC`/`ERR_OP` bit indices;
  - a `crc4_step` function (one bit in, next CRC out).
- Sub-module `mtm_alu_frame_rx` implements the bit FSM and outputs {byte_valid, is_cmd, byte, frame_err}.
- The packet layer (counter, CRC, output register) lives in the top module.

## Test plan
- **Good packet**: `N_OPS`=2, `DATA_W`=32; send B=0x00000002, A=0x00000001, op=ADD with the model CRC → one packet with `ops`=0x00000002_00000001, `op`=3'b100, `err`=0, valid 1 cycle after the stop bit.
- **Corrupted CRC**: same packet with the CRC LSB flipped → `err`=3'b010. Then send 7 data bytes and a cmd byte → `err`=3'b100.
- **Illegal opcode**: op=3'b111 with a correct CRC → `err`=3'b001. Re-run with `OP_MASK`=8'hFF → `err`=0.
- **Framing error**: stop bit 0 on the third data byte → immediate `err`=3'b100. The next good packet decodes correctly.
- **Backpressure**: hold `out_ready`=0 across two packets → first packet held stable, `drop` pulses exactly once. Release `out_ready` → first packet delivered, second lost.
- **Reset and other parameters**: assert `rst` for 1 cycle mid-byte → all outputs 0. Repeat the good-packet test with `DATA_W`=16, `N_OPS`=3 → 6 data bytes accepted, no errors.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared types, constants and the CRC4 step for the ALU serial front end.
// Imported by the frame receiver and the packet receiver.
package mtm_alu_pkg;

  localparam int   FRAME_LEN = 11;
  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD  = 1'b1;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_TYPE,
    F_BITS,
    F_STOP
  } frame_state_t;

  // Serial CRC over x^4+x+1: feedback folds x^4 back onto x+1.
  function automatic logic [3:0] crc4_step(
    input logic [3:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[3] ^ b;
    return {crc[2], crc[1], crc[0] ^ fb, fb};
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Bit-level receiver: start, type, 8 data bits MSB first, stop.
// Ports: clk, rst, sin in; byte_valid, is_cmd, data_byte, frame_err out.
module mtm_alu_frame_rx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       byte_valid,
  output logic       is_cmd,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  frame_state_t state, state_n;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         type_q;
  logic         hold;

  assign data_byte = shreg;
  assign is_cmd    = (type_q == TYPE_CMD);

  always_comb begin
    state_n    = state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      F_IDLE: if (!sin && !hold) state_n = F_TYPE;
      F_TYPE: state_n = F_BITS;
      F_BITS: if (bit_cnt == 3'd7) state_n = F_STOP;
      F_STOP: begin
        state_n = F_IDLE;
        if (sin) byte_valid = 1'b1;
        else     frame_err  = 1'b1;
      end
      default: state_n = F_IDLE;
    endcase
  end

  // hold: after a framing error the line must return high
  // before a new start bit counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= F_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      type_q  <= 1'b0;
      hold    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == F_TYPE) begin
        type_q  <= sin;
        bit_cnt <= 3'd0;
      end
      if (state == F_BITS) begin
        shreg   <= {shreg[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (frame_err)
        hold <= 1'b1;
      else if (state == F_IDLE && sin)
        hold <= 1'b0;
    end
  end

endmodule

// File: rtl/mtm_alu_packet_rx.sv
// Packet layer: operand assembly, byte count, CRC4, opcode check, 1-deep out reg.
// Ports: clk, rst, sin, out_ready in; out_valid, ops, op, err, drop out.
module mtm_alu_packet_rx
  import mtm_alu_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         N_OPS   = 2,
  parameter logic [7:0] OP_MASK = 8'b0011_0011
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OPS*DATA_W-1:0]   ops,
  output logic [2:0]                op,
  output logic [2:0]                err,
  output logic                      drop
);

  localparam int W  = N_OPS * DATA_W;
  localparam int NB = W / 8;
  localparam int CW = $clog2(NB + 2);
  localparam logic [CW-1:0] NB_C  = CW'(NB);
  localparam logic [CW-1:0] CNT_MAX = CW'(NB + 1);

  logic       byte_valid;
  logic       is_cmd;
  logic [7:0] data_byte;
  logic       frame_err;

  mtm_alu_frame_rx u_frame (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .byte_valid(byte_valid),
    .is_cmd    (is_cmd),
    .data_byte (data_byte),
    .frame_err (frame_err)
  );

  logic [CW-1:0] cnt;
  logic [3:0]    crc;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shifted;
  logic [3:0]    crc_data;
  logic [3:0]    crc_cmd;
  logic [2:0]    cmd_op;
  logic [3:0]    cmd_crc;
  logic [2:0]    err_n;
  logic          pkt_done;
  logic          data_in;
  logic          load;

  // Oldest bits fall off the top once the register is full.
  if (W == 8) begin : g_sh8
    assign shifted = data_byte;
  end else begin : g_shw
    assign shifted = {shreg[W-9:0], data_byte};
  end

  assign cmd_op   = data_byte[6:4];
  assign cmd_crc  = data_byte[3:0];
  assign data_in  = byte_valid & ~is_cmd;
  assign pkt_done = frame_err | (byte_valid & is_cmd);
  assign load     = pkt_done & (~out_valid | out_ready);

  always_comb begin
    crc_data = crc;
    for (int i = 7; i >= 0; i--)
      crc_data = crc4_step(crc_data, data_byte[i]);
    crc_cmd = crc4_step(crc, 1'b1);
    for (int i = 6; i >= 4; i--)
      crc_cmd = crc4_step(crc_cmd, data_byte[i]);
  end

  always_comb begin
    err_n = 3'b000;
    if (frame_err)
      err_n[ERR_DATA] = 1'b1;
    else if (cnt != NB_C)
      err_n[ERR_DATA] = 1'b1;
    else if (cmd_crc != crc_cmd)
      err_n[ERR_CRC] = 1'b1;
    else if (!OP_MASK[cmd_op])
      err_n[ERR_OP] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      crc   <= 4'd0;
      shreg <= '0;
    end else if (pkt_done) begin
      cnt   <= '0;
      crc   <= 4'd0;
      shreg <= '0;
    end else if (data_in) begin
      shreg <= shifted;
      crc   <= crc_data;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ops       <= '0;
      op        <= 3'd0;
      err       <= 3'd0;
      drop      <= 1'b0;
    end else begin
      drop <= pkt_done & out_valid & ~out_ready;
      if (load) begin
        out_valid <= 1'b1;
        ops       <= frame_err ? '0 : shreg;
        op        <= frame_err ? 3'd0 : cmd_op;
        err       <= err_n;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_packet_rx.sv
// Scoreboard bench for mtm_alu_packet_rx over three parameter sets.
// One shared serial line is steered to the instance under test by sel.
module tb_mtm_alu_packet_rx;
  import mtm_alu_pkg::*;

  logic clk = 1'b0;
  logic rst, sin, rdy;
  int   sel;
  always #5 clk = ~clk;

  logic s0, s1, s2, r0, r1, r2;
  assign s0 = (sel == 0) ? sin : 1'b1;
  assign s1 = (sel == 1) ? sin : 1'b1;
  assign s2 = (sel == 2) ? sin : 1'b1;
  assign r0 = rdy & (sel == 0);
  assign r1 = rdy & (sel == 1);
  assign r2 = rdy & (sel == 2);

  logic v0, v1, v2, d0, d1, d2;
  logic [2:0] op0, op1, op2, e0, e1, e2;
  logic [63:0] ops0, ops1;
  logic [47:0] ops2;

  mtm_alu_packet_rx dut0 (
    .clk(clk), .rst(rst), .sin(s0), .out_valid(v0), .out_ready(r0),
    .ops(ops0), .op(op0), .err(e0), .drop(d0));
  mtm_alu_packet_rx #(.OP_MASK(8'hFF)) dut1 (
    .clk(clk), .rst(rst), .sin(s1), .out_valid(v1), .out_ready(r1),
    .ops(ops1), .op(op1), .err(e1), .drop(d1));
  mtm_alu_packet_rx #(.DATA_W(16), .N_OPS(3)) dut2 (
    .clk(clk), .rst(rst), .sin(s2), .out_valid(v2), .out_ready(r2),
    .ops(ops2), .op(op2), .err(e2), .drop(d2));

  logic        o_valid, o_drop;
  logic [95:0] o_ops;
  logic [2:0]  o_op, o_err;

  always_comb begin
    o_valid = v0; o_drop = d0; o_ops = {32'd0, ops0}; o_op = op0; o_err = e0;
    if (sel == 1) begin
      o_valid = v1; o_drop = d1; o_ops = {32'd0, ops1}; o_op = op1; o_err = e1;
    end else if (sel == 2) begin
      o_valid = v2; o_drop = d2; o_ops = {48'd0, ops2}; o_op = op2; o_err = e2;
    end
  end

  typedef struct packed {
    logic [95:0] ops;
    logic [2:0]  op;
    logic [2:0]  err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tx[$];
  int total = 0;
  int passed = 0;

  // CRC as polynomial long division of (message * x^4) by x^4+x+1.
  function automatic logic [3:0] model_crc(input logic [2:0] opc);
    logic [4:0] r;
    logic       bits[$];
    r = 5'd0;
    foreach (tx[i]) for (int k = 7; k >= 0; k--) bits.push_back(tx[i][k]);
    bits.push_back(1'b1);
    for (int k = 2; k >= 0; k--) bits.push_back(opc[k]);
    for (int k = 0; k < 4; k++) bits.push_back(1'b0);
    foreach (bits[i]) begin
      r = {r[3:0], bits[i]};
      if (r[4]) r = r ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [95:0] model_ops(input int w);
    logic [95:0] e;
    e = 96'd0;
    foreach (tx[i]) e = (e << 8) | {88'd0, tx[i]};
    return e & ((96'd1 << w) - 96'd1);
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_packet(input logic [2:0] opc, input logic [3:0] flip);
    foreach (tx[i]) send_byte(TYPE_DATA, tx[i], 1'b1);
    send_byte(TYPE_CMD, {1'b0, opc, model_crc(opc) ^ flip}, 1'b1);
  endtask

  task automatic take(output exp_t got, output exp_t want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (o_valid) ok = 1'b1;
      else @(negedge clk);
    end
    got = '{ops: o_ops, op: o_op, err: o_err};
    want = (sb.size() > 0) ? sb.pop_front() : '0;
  endtask

  task automatic accept();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 1'b1; rdy = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_valid, o_ops, o_op, o_err, o_drop} !== 104'd0)
      $display("FAIL reset_outputs got v=%b ops=%h op=%b err=%b drop=%b want all 0",
               o_valid, o_ops, o_op, o_err, o_drop);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good();
    exp_t g, w; bit ok;
    sel = 0;
    tx = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
    sb.push_back('{ops: 96'h00000002_00000001, op: 3'b100, err: 3'b000});
    send_packet(OP_ADD, 4'h0);
    total++;
    if (o_valid !== 1'b1) $display("FAIL good_latency got valid=%b want 1", o_valid);
    else passed++;
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL good_packet got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    total++;
    if (o_valid !== 1'b0) $display("FAIL good_handshake got valid=%b want 0", o_valid);
    else passed++;
  endtask

  task automatic test_crc();
    exp_t g, w; bit ok;
    sel = 0;
    tx = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
    sb.push_back('{ops: 96'h00000002_00000001, op: 3'b100, err: 3'b010});
    send_packet(OP_ADD, 4'h1);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL crc_flip got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    sb.push_back('{ops: 96'h00112233_44556677, op: 3'b100, err: 3'b100});
    send_packet(OP_ADD, 4'h0);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL short_count got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    tx = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    sb.push_back('{ops: 96'hA2A3A4A5_A6A7A8A9, op: 3'b000, err: 3'b100});
    send_packet(OP_AND, 4'h0);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL long_count got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    tx = {};
    sb.push_back('{ops: 96'd0, op: 3'b101, err: 3'b100});
    send_packet(OP_SUB, 4'h0);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL zero_count got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
  endtask

  task automatic test_op();
    exp_t g, w; bit ok;
    sel = 0;
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    sb.push_back('{ops: model_ops(64), op: 3'b111, err: 3'b001});
    send_packet(3'b111, 4'h0);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL illegal_op got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    sel = 1;
    sb.push_back('{ops: 96'hDEADBEEF_01234567, op: 3'b111, err: 3'b000});
    send_packet(3'b111, 4'h0);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL open_mask got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    sel = 0;
  endtask

  task automatic test_framing();
    exp_t g, w; bit ok;
    sel = 0;
    sb.push_back('{ops: 96'd0, op: 3'b000, err: 3'b100});
    send_byte(TYPE_DATA, 8'h11, 1'b1);
    send_byte(TYPE_DATA, 8'h22, 1'b1);
    send_byte(TYPE_DATA, 8'h33, 1'b0);
    total++;
    if (o_valid !== 1'b1) $display("FAIL frame_latency got valid=%b want 1", o_valid);
    else passed++;
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL frame_err got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    send_bit(1'b1);
    tx = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h10, 8'h20, 8'h30, 8'h40};
    sb.push_back('{ops: 96'h0A0B0C0D_10203040, op: 3'b001, err: 3'b000});
    send_packet(OP_OR, 4'h0);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL after_frame got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
  endtask

  task automatic test_backpressure();
    exp_t g, w, saved; bit ok;
    int drops; bit unstable;
    sel = 0; drops = 0; unstable = 1'b0;
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    sb.push_back('{ops: 96'h01020304_05060708, op: 3'b101, err: 3'b000});
    send_packet(OP_SUB, 4'h0);
    saved = '{ops: o_ops, op: o_op, err: o_err};
    tx = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8};
    fork
      send_packet(OP_ADD, 4'h0);
      begin
        repeat (9 * FRAME_LEN + 5) begin
          @(negedge clk);
          if (o_drop === 1'b1) drops++;
          if ({o_valid, o_ops, o_op, o_err} !== {1'b1, saved}) unstable = 1'b1;
        end
      end
    join
    total++;
    if (unstable) $display("FAIL bp_stable got changing outputs want held");
    else passed++;
    total++;
    if (drops != 1) $display("FAIL bp_drop got %0d pulses want 1", drops);
    else passed++;
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL bp_first got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    repeat (3) @(negedge clk);
    total++;
    if (o_valid !== 1'b0) $display("FAIL bp_second_lost got valid=%b want 0", o_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t g, w; bit ok;
    sel = 0;
    tx = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    send_packet(OP_AND, 4'h0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    #1;
    total++;
    if ({o_valid, o_ops, o_op, o_err, o_drop} !== 104'd0)
      $display("FAIL mid_reset got v=%b ops=%h op=%b err=%b drop=%b want all 0",
               o_valid, o_ops, o_op, o_err, o_drop);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    send_bit(1'b1);
    sb.push_back('{ops: 96'h55555555_AAAAAAAA, op: 3'b000, err: 3'b000});
    send_packet(OP_AND, 4'h0);
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL after_reset got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
  endtask

  task automatic test_params();
    exp_t g, w; bit ok;
    sel = 2;
    tx = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h03};
    sb.push_back('{ops: 96'h0002_0001_0003, op: 3'b100, err: 3'b000});
    send_packet(OP_ADD, 4'h0);
    total++;
    if (o_valid !== 1'b1) $display("FAIL p16_latency got valid=%b want 1", o_valid);
    else passed++;
    take(g, w, ok);
    total++;
    if (!ok || g !== w)
      $display("FAIL p16_packet got %h/%b/%b want %h/%b/%b", g.ops, g.op, g.err, w.ops, w.op, w.err);
    else passed++;
    accept();
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_good();
    test_crc();
    test_op();
    test_framing();
    test_backpressure();
    test_reset_mid();
    test_params();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
